// File: rtl/md_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_ctrl_pkg
// Description : Shared op codes, latency defaults and state encoding for the
//               HI/LO multiply-divide issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
package md_issue_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  function automatic logic is_issue_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

  // Ops that occupy the unit for a multi-cycle countdown.
  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage : md_issue_ctrl_pkg
`default_nettype wire

// File: rtl/md_busy_cnt.sv
`default_nettype none
// ============================================================================
// Module      : md_busy_cnt
// Description : Loadable down-counter with zero detect; tracks remaining
//               multiply/divide latency.
// Revision    : 1.0 - initial release
// ============================================================================
module md_busy_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Decrement saturates at zero so the count can never wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule : md_busy_cnt
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_ctrl
// Description : EX-stage issue sequencer for the HI/LO multiply-divide unit;
//               issues op pulses, tracks busy latency, generates D-stall.
// Revision    : 1.0 - initial release
// ============================================================================
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        flush,
  input  logic        id_hilo_use,
  output logic [3:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        busy,
  output logic        stall_d,
  output logic        err
);

  localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] c_div_load = CNT_W'(DIV_LAT - 1);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [3:0]       r_md_op;
  logic [31:0]      r_md_a;
  logic [31:0]      r_md_b;
  logic             r_err;

  logic             w_issue_req;
  logic             w_muldiv_req;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic [3:0]       w_md_op_nxt;
  logic             w_opnd_load;
  logic             w_err_set;

  assign w_issue_req  = ex_valid & ~flush & is_issue_op(ex_op);
  assign w_muldiv_req = w_issue_req & is_muldiv_op(ex_op);

  md_busy_cnt #(
    .CNT_W (CNT_W)
  ) u_busy_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = c_mul_load;
    w_cnt_dec      = 1'b0;
    w_md_op_nxt    = MD_NONE;
    w_opnd_load    = 1'b0;
    w_err_set      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue_req) begin
          w_md_op_nxt = ex_op;
          w_opnd_load = 1'b1;
          if (w_muldiv_req) begin
            w_state_nxt    = ST_BUSY;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = is_mul_op(ex_op) ? c_mul_load : c_div_load;
          end
        end
      end
      ST_BUSY: begin
        // A request here means the upstream stall was bypassed; drop it.
        w_err_set = w_issue_req;
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_op <= MD_NONE;
      r_md_a  <= '0;
      r_md_b  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_md_op <= w_md_op_nxt;
      if (w_opnd_load) begin
        r_md_a <= ex_rs;
        r_md_b <= ex_rt;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign md_op = r_md_op;
  assign md_a  = r_md_a;
  assign md_b  = r_md_b;
  assign busy  = (r_state == ST_BUSY);
  assign err   = r_err;

  // Issue-cycle term holds back a dependent instruction right behind mult/div.
  assign stall_d = id_hilo_use & (busy | w_muldiv_req);

endmodule : md_issue_ctrl
`default_nettype wire
